// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: oversampled start detection, 3-sample mid-bit majority vote,
// framing/overrun pulses and a first-word-fall-through byte FIFO with valid/ready.
module uart_rx_deserializer #(
  parameter int RX_OVERSAMPLE = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_Rx_ClkTick,
  input  logic                          i_Rx_Data,
  input  logic                          i_Rx_Ready,
  output logic                          o_Rx_Valid,
  output logic [7:0]                    o_Rx_Byte,
  output logic [$clog2(FIFO_DEPTH):0]   o_Rx_Count,
  output logic                          o_Frame_Error,
  output logic                          o_Overrun
);
  localparam int TW = $clog2(RX_OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int M  = RX_OVERSAMPLE / 2;
  localparam logic [TW-1:0] T_LAST = TW'(RX_OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_VA   = TW'(M - 1);
  localparam logic [TW-1:0] T_VB   = TW'(M);
  localparam logic [TW-1:0] T_VC   = TW'(M + 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic            rx_m, rx_s, armed;
  logic [TW-1:0]   t, t_cur;
  logic [2:0]      bit_idx;
  logic            smp_a, smp_b, vote, vote_now, wrap;
  logic [7:0]      shift_r;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            full, pop, push, frame_err, overrun;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_Rx_Data;
      rx_s <= rx_m;
    end
  end

  // t_cur is the index of the tick arriving this cycle; the third vote sample is rx_s itself
  assign t_cur    = (t == T_LAST) ? '0 : t + 1'b1;
  assign wrap     = i_Rx_ClkTick && (t == T_LAST);
  assign vote_now = i_Rx_ClkTick && (t_cur == T_VC);
  assign vote     = majority3(smp_a, smp_b, rx_s);

  assign o_Rx_Count = wr_ptr - rd_ptr;
  assign o_Rx_Valid = (o_Rx_Count != '0);
  assign full       = (o_Rx_Count == CNT_FULL);
  assign pop        = o_Rx_Valid && i_Rx_Ready;
  assign o_Rx_Byte  = o_Rx_Valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    frame_err = 1'b0;
    overrun   = 1'b0;
    case (state)
      IDLE:  if (i_Rx_ClkTick && armed && !rx_s) state_nxt = START;
      START: begin
        if (vote_now && vote) state_nxt = IDLE;
        else if (wrap)        state_nxt = DATA;
      end
      DATA:  if (wrap && bit_idx == 3'd7) state_nxt = STOP;
      STOP: begin
        // Leave at the vote so a back-to-back start bit is not missed
        if (vote_now) begin
          state_nxt = IDLE;
          if (!vote)              frame_err = 1'b1;
          else if (!full || pop)  push      = 1'b1;
          else                    overrun   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed         <= 1'b0;
      t             <= '0;
      bit_idx       <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_Frame_Error <= 1'b0;
      o_Overrun     <= 1'b0;
    end else begin
      // Only a high line re-arms detection, so a held break cannot retrigger
      if (state == IDLE && i_Rx_ClkTick) armed <= rx_s;
      if (state == IDLE || state_nxt == IDLE) t <= '0;
      else if (i_Rx_ClkTick)                  t <= t_cur;
      if (state != DATA) bit_idx <= '0;
      else if (wrap)     bit_idx <= bit_idx + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      o_Frame_Error <= frame_err;
      o_Overrun     <= overrun;
    end
  end

  always_ff @(posedge clk) begin
    if (i_Rx_ClkTick && t_cur == T_VA) smp_a <= rx_s;
    if (i_Rx_ClkTick && t_cur == T_VB) smp_b <= rx_s;
    if (state == DATA && vote_now) shift_r <= {vote, shift_r[7:1]};
    if (push) mem[wr_ptr[AW-1:0]] <= shift_r;
  end

endmodule
